drawfont_stream: RTL and testbench

Parametrised glyph rasteriser and successor to the fixed 5x8 font drawer. It takes one character draw command and streams pixel coordinates from a column-major font ROM to the pixel writer. Over the previous generation it adds:
- configurable glyph geometry
- independent X/Y scaling
- opaque (background-filling) mode
- right/bottom-edge clipping
- a valid/ready output handshake in place of a free-running clock enable

It sits between the GPU command decoder and the framebuffer write arbiter.

---
 rtl/drawfont_stream.sv | 184 ++++++++++++++++++
 tb/tb_drawfont_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drawfont_stream.sv
// Glyph rasteriser: fetches column-major font words and streams scaled, clipped
// pixel coordinates to the framebuffer writer through a single-entry valid/ready register.
module drawfont_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int GLYPH_W    = 5,
    parameter int GLYPH_H    = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] char,
    input  logic [DATA_WIDTH-1:0] scale_x,
    input  logic [DATA_WIDTH-1:0] scale_y,
    input  logic                  opaque,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [GLYPH_H-1:0]    rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_fg
);

    localparam int CW = DATA_WIDTH + 4;
    localparam logic [CW-1:0] LIMIT    = {4'b0001, {DATA_WIDTH{1'b0}}};
    localparam logic [3:0]    LAST_COL = 4'(GLYPH_W - 1);
    localparam logic [3:0]    LAST_ROW = 4'(GLYPH_H - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAW  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic                  fetch_ph;
    logic [DATA_WIDTH-1:0] y0_q, scale_x_q, scale_y_q;
    logic                  opaque_q;
    logic [GLYPH_H-1:0]    col_reg;
    logic [3:0]            col, row;
    logic [DATA_WIDTH-1:0] sx, sy;
    logic [CW-1:0]         col_x, pix_x, row_y, pix_y;

    logic [ADDR_WIDTH-1:0] base_addr;
    logic [15:0]           col_ext;
    logic                  pix_bit, clipped, emit, advance;
    logic                  last_sx, last_sy;

    // Bases saturate at LIMIT so the narrow accumulators can never wrap back into range.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
        logic [CW-1:0] s;
        s = a + CW'(b);
        return (s > LIMIT) ? LIMIT : s;
    endfunction

    assign base_addr = ADDR_WIDTH'(int'(char) * GLYPH_W);
    assign col_ext   = 16'(col_reg);
    assign pix_bit   = col_ext[row];
    assign clipped   = (pix_x >= LIMIT) || (pix_y >= LIMIT);
    assign emit      = !clipped && (opaque_q || pix_bit);
    assign advance   = (state == S_DRAW) && (!out_valid || out_ready);
    assign last_sx   = (sx == scale_x_q - 1'b1);
    assign last_sy   = (sy == scale_y_q - 1'b1);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fetch_ph  <= 1'b0;
            y0_q      <= '0;
            scale_x_q <= '0;
            scale_y_q <= '0;
            opaque_q  <= 1'b0;
            col_reg   <= '0;
            col       <= '0;
            row       <= '0;
            sx        <= '0;
            sy        <= '0;
            col_x     <= '0;
            pix_x     <= '0;
            row_y     <= '0;
            pix_y     <= '0;
            rom_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        y0_q      <= y0;
                        scale_x_q <= (scale_x == '0) ? DATA_WIDTH'(1) : scale_x;
                        scale_y_q <= (scale_y == '0) ? DATA_WIDTH'(1) : scale_y;
                        opaque_q  <= opaque;
                        rom_addr  <= base_addr;
                        col       <= '0;
                        row       <= '0;
                        sx        <= '0;
                        sy        <= '0;
                        col_x     <= CW'(x0);
                        pix_x     <= CW'(x0);
                        row_y     <= CW'(y0);
                        pix_y     <= CW'(y0);
                        fetch_ph  <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        col_reg  <= rom_data;
                        state    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (advance) begin
                        if (!last_sx) begin
                            sx    <= sx + 1'b1;
                            pix_x <= pix_x + 1'b1;
                        end else begin
                            sx    <= '0;
                            pix_x <= col_x;
                            if (!last_sy) begin
                                sy    <= sy + 1'b1;
                                pix_y <= pix_y + 1'b1;
                            end else begin
                                sy <= '0;
                                if (row != LAST_ROW) begin
                                    row   <= row + 1'b1;
                                    row_y <= sat_add(row_y, scale_y_q);
                                    pix_y <= sat_add(row_y, scale_y_q);
                                end else begin
                                    row   <= '0;
                                    row_y <= CW'(y0_q);
                                    pix_y <= CW'(y0_q);
                                    col_x <= sat_add(col_x, scale_x_q);
                                    pix_x <= sat_add(col_x, scale_x_q);
                                    if (col == LAST_COL) begin
                                        state <= S_DRAIN;
                                    end else begin
                                        col      <= col + 1'b1;
                                        rom_addr <= rom_addr + 1'b1;
                                        state    <= S_FETCH;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!out_valid) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_fg    <= 1'b0;
        end else if (advance) begin
            out_valid <= emit;
            if (emit) begin
                out_x  <= pix_x[DATA_WIDTH-1:0];
                out_y  <= pix_y[DATA_WIDTH-1:0];
                out_fg <= pix_bit;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_drawfont_stream.sv
// Self-checking bench for drawfont_stream: a loop-based pixel model fed from a
// small font table, checked on every handshake plus literal scenario expectations.
module tb_drawfont_stream;

    localparam int DW = 8;
    localparam int GW = 5;
    localparam int GH = 8;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] x0 = '0, y0 = '0, chr = '0, scale_x = '0, scale_y = '0;
    logic          opaque = 1'b0;
    logic          busy, done;
    logic [AW-1:0] rom_addr;
    logic [GH-1:0] rom_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_x, out_y;
    logic          out_fg;

    drawfont_stream #(.DATA_WIDTH(DW), .GLYPH_W(GW), .GLYPH_H(GH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x0(x0), .y0(y0), .char(chr),
        .scale_x(scale_x), .scale_y(scale_y), .opaque(opaque), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_fg(out_fg)
    );

    always #5 clk = ~clk;

    logic [GH-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {int x; int y; bit fg;} pix_t;
    pix_t exp_q[$];
    pix_t obs_q[$];
    int   addr_q[$];
    int   tests = 0, fails = 0, done_cnt = 0;
    int   cur_ch = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Expected stream straight from the geometry rules: nested loops and integer maths.
    task automatic build_model(input int bx, input int by, input int ch,
                               input int scx, input int scy, input bit opq);
        int   sxe, sye, x, y;
        bit   b;
        pix_t p;
        sxe = (scx == 0) ? 1 : scx;
        sye = (scy == 0) ? 1 : scy;
        exp_q.delete();
        for (int c = 0; c < GW; c++)
            for (int r = 0; r < GH; r++)
                for (int j = 0; j < sye; j++)
                    for (int i = 0; i < sxe; i++) begin
                        x = bx + c * sxe + i;
                        y = by + r * sye + j;
                        b = rom[(ch * GW + c) % (1 << AW)][r];
                        if (x < 256 && y < 256 && (opq || b)) begin
                            p.x = x; p.y = y; p.fg = b;
                            exp_q.push_back(p);
                        end
                    end
    endtask

    initial begin
        random_ready_driver();
    end

    task automatic random_ready_driver();
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        compare_loop();
    end

    task automatic compare_loop();
        pix_t          e, o;
        bit            prev_stall;
        logic [DW-1:0] px, py;
        logic          pf;
        prev_stall = 1'b0;
        px = '0; py = '0; pf = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_x", int'(out_x), int'(px));
                    chk("hold_y", int'(out_y), int'(py));
                    chk("hold_fg", int'(out_fg), int'(pf));
                end
                if (out_valid && out_ready) begin
                    o.x = int'(out_x); o.y = int'(out_y); o.fg = out_fg;
                    obs_q.push_back(o);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_pixel: got (%0d,%0d), expected none", o.x, o.y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_x", o.x, e.x);
                        chk("pix_y", o.y, e.y);
                        chk("pix_fg", int'(o.fg), int'(e.fg));
                    end
                end
                prev_stall = out_valid && !out_ready;
                px = out_x; py = out_y; pf = out_fg;
                if (busy && (addr_q.size() == 0 || addr_q[$] != int'(rom_addr)))
                    addr_q.push_back(int'(rom_addr));
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic issue(input int bx, input int by, input int ch,
                         input int scx, input int scy, input bit opq);
        build_model(bx, by, ch, scx, scy, opq);
        obs_q.delete();
        addr_q.delete();
        done_cnt = 0;
        cur_ch   = ch;
        @(posedge clk);
        #1;
        x0 = DW'(bx); y0 = DW'(by); chr = DW'(ch);
        scale_x = DW'(scx); scale_y = DW'(scy); opaque = opq;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int inject_at);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (i == inject_at) begin
                start = 1'b1; chr = 8'h42; x0 = 8'd50; y0 = 8'd60; opaque = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", int'(ok), 1);
        chk("model_drained_at_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("done_pulses", done_cnt, 1);
        chk("fetch_count", addr_q.size(), GW);
        for (int i = 0; i < addr_q.size() && i < GW; i++)
            chk("rom_addr", addr_q[i], (cur_ch * GW + i) % (1 << AW));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_x"}, int'(out_x), 0);
        chk({tag, "_y"}, int'(out_y), 0);
        chk({tag, "_fg"}, int'(out_fg), 0);
        chk({tag, "_addr"}, int'(rom_addr), 0);
    endtask

    task automatic check_a_1x1(input string tag);
        chk({tag, "_count"}, obs_q.size(), 16);
        if (obs_q.size() > 0) begin
            chk({tag, "_first_x"}, obs_q[0].x, 10);
            chk({tag, "_first_y"}, obs_q[0].y, 22);
            chk({tag, "_last_x"}, obs_q[$].x, 14);
            chk({tag, "_last_y"}, obs_q[$].y, 26);
        end
    endtask

    initial begin
        int fg_cnt, max_x, max_y, min_x;
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        rom[11'h145] = 8'h7C; rom[11'h146] = 8'h12; rom[11'h147] = 8'h11;
        rom[11'h148] = 8'h12; rom[11'h149] = 8'h7C;
        rom[11'h14A] = 8'h7F; rom[11'h14B] = 8'h49; rom[11'h14C] = 8'h49;
        rom[11'h14D] = 8'h49; rom[11'h14E] = 8'h36;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Transparent 1x1
        issue(10, 20, 8'h41, 1, 1, 1'b0);
        chk("model_a_count", exp_q.size(), 16);
        wait_done(-1);
        check_a_1x1("transparent");

        // Opaque 2x3
        issue(0, 0, 8'h41, 2, 3, 1'b1);
        wait_done(-1);
        chk("opaque_count", obs_q.size(), 240);
        fg_cnt = 0; max_x = 0; max_y = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].fg) fg_cnt++;
            if (obs_q[i].x > max_x) max_x = obs_q[i].x;
            if (obs_q[i].y > max_y) max_y = obs_q[i].y;
        end
        chk("opaque_fg_count", fg_cnt, 96);
        chk("opaque_max_x", max_x, 9);
        chk("opaque_max_y", max_y, 23);
        if (obs_q.size() >= 2) begin
            chk("opaque_p0_x", obs_q[0].x, 0);
            chk("opaque_p0_y", obs_q[0].y, 0);
            chk("opaque_p0_fg", int'(obs_q[0].fg), 0);
            chk("opaque_p1_x", obs_q[1].x, 1);
            chk("opaque_p1_y", obs_q[1].y, 0);
            chk("opaque_p1_fg", int'(obs_q[1].fg), 0);
        end

        // Backpressure
        rand_ready = 1'b1;
        issue(10, 20, 8'h41, 1, 1, 1'b0);
        wait_done(-1);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        check_a_1x1("backpressure");

        // Right-edge clipping
        issue(254, 0, 8'h41, 1, 1, 1'b1);
        wait_done(-1);
        chk("clip_count", obs_q.size(), 16);
        max_x = 0; min_x = 1000;
        foreach (obs_q[i]) begin
            if (obs_q[i].x > max_x) max_x = obs_q[i].x;
            if (obs_q[i].x < min_x) min_x = obs_q[i].x;
        end
        chk("clip_max_x", max_x, 255);
        chk("clip_min_x", min_x, 254);

        // Scale 0 with an ignored second start
        issue(10, 20, 8'h41, 0, 0, 1'b0);
        wait_done(8);
        check_a_1x1("scale0_restart");

        // Reset mid-draw
        issue(10, 20, 8'h41, 1, 1, 1'b0);
        for (int i = 0; i < 500 && obs_q.size() < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_5th_pixel", int'(obs_q.size() >= 5), 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_on_reset", done_cnt, 0);
        reset_n = 1'b1;
        issue(10, 20, 8'h41, 1, 1, 1'b0);
        wait_done(-1);
        check_a_1x1("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
